// File: rtl/psg_pkg.sv
// -----------------------------------------------------------------------------
// psg_pkg
// Shared definitions for the PSG wave-table fetch path: channel count,
// default bus widths and the fetch FSM state type.
// -----------------------------------------------------------------------------
package psg_pkg;

  localparam int PSG_NCH = 8;   // wave-table channels behind the arbiter
  localparam int PSG_AW  = 24;  // default system byte-address width
  localparam int PSG_DW  = 16;  // default sample fetch width

  // ARB: arbiter may re-arbitrate; CHK: grant being validated; BUS: read cycle.
  typedef enum logic [1:0] {
    ARB = 2'd0,
    CHK = 2'd1,
    BUS = 2'd2
  } psg_state_e;

endpackage

// File: rtl/psg_addr_mux.sv
// -----------------------------------------------------------------------------
// psg_addr_mux
// Combinational 8:1 selector that picks the granted channel's fetch address
// out of the flattened per-channel address bus.
//
// Ports:
//   addr_flat  in  PSG_NCH*AW  channel n at [n*AW +: AW]
//   seln       in  3           encoded grant
//   addr       out AW          address of channel seln
// -----------------------------------------------------------------------------
module psg_addr_mux
  import psg_pkg::*;
#(
  parameter int AW = PSG_AW
) (
  input  logic [PSG_NCH*AW-1:0] addr_flat,
  input  logic [2:0]            seln,
  output logic [AW-1:0]         addr
);

  // NOTE: every signal driven from always_comb gets a default before any
  // conditional assignment, otherwise an uncovered path infers a latch.
  always_comb begin
    addr = '0;
    for (int i = 0; i < PSG_NCH; i++) begin
      if (seln == 3'(i)) addr = addr_flat[i*AW +: AW];
    end
  end

endmodule

// File: rtl/psg_wt_fetch.sv
// -----------------------------------------------------------------------------
// psg_wt_fetch
// Bus master sitting directly after the PSG eight-channel arbiter. It takes the
// arbiter's grant, runs one read on the system bus for that wave-table channel
// and returns the sample tagged with its channel. arb_ack tells the arbiter
// when it may re-arbitrate, so grants only change between transfers.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   ce           PSG clock enable (shared with the arbiter)
//   req[7:0]     per-channel fetch requests
//   sel[7:0]     one-hot grant, seln[2:0] encoded grant
//   addr_flat    per-channel fetch addresses, channel n at [n*AW +: AW]
//   arb_ack      bus free; arbiter re-arbitrates on ce & arb_ack
//   m_cyc/m_stb/m_we/m_adr, m_ack_i/m_dat_i   system-bus read master
//   dat_o, dat_ch, dat_vld   fetched sample, owning channel, 1-clk valid
//   err          1-clk pulse when the bus does not acknowledge in time
// -----------------------------------------------------------------------------
module psg_wt_fetch
  import psg_pkg::*;
#(
  parameter int AW        = PSG_AW,
  parameter int DW        = PSG_DW,
  parameter int TO_CYCLES = 255       // 1..255 clks before a read is abandoned
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [PSG_NCH-1:0]    req,
  input  logic [PSG_NCH-1:0]    sel,
  input  logic [2:0]            seln,
  input  logic [PSG_NCH*AW-1:0] addr_flat,
  output logic                  arb_ack,
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [AW-1:0]         m_adr,
  input  logic                  m_ack_i,
  input  logic [DW-1:0]         m_dat_i,
  output logic [DW-1:0]         dat_o,
  output logic                  dat_vld,
  output logic [2:0]            dat_ch,
  output logic                  err
);

  localparam logic [7:0] CNT_LAST = 8'(TO_CYCLES - 1);

  psg_state_e    state_q, state_d;
  logic          arb_ack_q, arb_ack_d;
  logic          cyc_q, cyc_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [2:0]    ch_q, ch_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [2:0]    dat_ch_q, dat_ch_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [AW-1:0] mux_adr;

  psg_addr_mux #(.AW(AW)) u_addr_mux (
    .addr_flat (addr_flat),
    .seln      (seln),
    .addr      (mux_adr)
  );

  // Next-state and next-output logic. ARB/CHK advance only on ce so the
  // arbiter and this stage step together; BUS runs at full clk rate.
  always_comb begin
    state_d   = state_q;
    arb_ack_d = arb_ack_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    dat_ch_d  = dat_ch_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ARB: begin
        if (ce) begin
          state_d   = CHK;
          arb_ack_d = 1'b0;
        end
      end

      CHK: begin
        if (ce) begin
          // The arbiter holds its last owner even after that requester has
          // gone idle, so a grant is only acted on if its req is still up.
          if (|sel && req[seln]) begin
            ch_d    = seln;
            adr_d   = mux_adr;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
          end else begin
            state_d   = ARB;
            arb_ack_d = 1'b1;
          end
        end
      end

      BUS: begin
        cnt_d = cnt_q + 8'd1;
        // Acknowledge is checked first so a late ack on the final count
        // still delivers data instead of a timeout.
        if (m_ack_i) begin
          dat_d     = m_dat_i;
          dat_ch_d  = ch_q;
          vld_d     = 1'b1;
          cyc_d     = 1'b0;
          state_d   = ARB;
          arb_ack_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          err_d     = 1'b1;
          cyc_d     = 1'b0;
          state_d   = ARB;
          arb_ack_d = 1'b1;
        end
      end

      default: begin
        state_d   = ARB;
        arb_ack_d = 1'b1;
        cyc_d     = 1'b0;
      end
    endcase
  end

  // NOTE: every register here, including data/address holding registers, is
  // given a reset value so the bus interface and outputs are defined from the
  // first clk after reset, not just the FSM state.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    if (rst) begin
      state_q   <= ARB;
      arb_ack_q <= 1'b1;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      dat_q     <= '0;
      dat_ch_q  <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_ack_q <= arb_ack_d;
      cyc_q     <= cyc_d;
      adr_q     <= adr_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      dat_q     <= dat_d;
      dat_ch_q  <= dat_ch_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign arb_ack = arb_ack_q;
  assign m_cyc   = cyc_q;
  assign m_stb   = cyc_q;   // single-beat reads: strobe tracks the cycle
  assign m_we    = 1'b0;
  assign m_adr   = adr_q;
  assign dat_o   = dat_q;
  assign dat_ch  = dat_ch_q;
  assign dat_vld = vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_psg_wt_fetch.sv
// -----------------------------------------------------------------------------
// tb_psg_wt_fetch
// Directed and randomized checks of psg_wt_fetch. The bench plays the arbiter
// (grant changes only while arb_ack is high) and the bus slave. Expected
// results come from transaction-level rules: a grant is served only if sel is
// non-zero and req[seln] is set; an ack issued d clks after m_cyc rises wins if
// d < TO, so m_cyc lasts min(d, TO-1)+1 clks; otherwise err fires and dat_o
// keeps its previous value.
// -----------------------------------------------------------------------------
module tb_psg_wt_fetch;

  localparam int AW     = 24;
  localparam int DW     = 16;
  localparam int TO     = 4;
  localparam int CE_DIV = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce = 1'b0;
  logic [7:0]      req, sel;
  logic [2:0]      seln;
  logic [8*AW-1:0] addr_flat;
  logic            arb_ack, m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_adr;
  logic            m_ack_i;
  logic [DW-1:0]   m_dat_i, dat_o;
  logic            dat_vld, err;
  logic [2:0]      dat_ch;

  int              errors = 0;
  int              checks = 0;
  int              ce_div = 0;
  logic [DW-1:0]   exp_dat = '0;   // model of the dat_o holding register

  psg_wt_fetch #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req       (req),
    .sel       (sel),
    .seln      (seln),
    .addr_flat (addr_flat),
    .arb_ack   (arb_ack),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_ack_i   (m_ack_i),
    .m_dat_i   (m_dat_i),
    .dat_o     (dat_o),
    .dat_vld   (dat_vld),
    .dat_ch    (dat_ch),
    .err       (err)
  );

  always #5 clk = ~clk;

  // ce: one clk in every CE_DIV, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      ce = (ce_div == 0);
      ce_div = (ce_div + 1) % CE_DIV;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the next edge at which ce was high.
  task automatic wait_ce();
    for (int i = 0; i < CE_DIV + 1; i++) begin
      step();
      if (ce) return;
    end
    check("ce_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 * CE_DIV; i++) begin
      if (arb_ack) return;
      step();
    end
    check("arb_ack_wait", 32'(arb_ack), 32'd1);
  endtask

  // One arbiter grant. dly = clks after m_cyc rises before a 1-clk ack pulse.
  task automatic run_txn(input int ch, input logic [7:0] sel_v, input logic [7:0] req_v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d_v,
                         input int dly, input bit rst_mid);
    bit expect_bus;
    int lat, cyc_clks, nvld, nerr;
    wait_idle();
    seln = 3'(ch);
    sel  = sel_v;
    req  = req_v;
    addr_flat[ch*AW +: AW] = a;
    expect_bus = (sel_v != 8'h00) && req_v[ch];

    if (!expect_bus) begin
      wait_ce();
      check("nogrant_chk_ack", 32'(arb_ack), 32'd0);
      wait_ce();
      check("nogrant_back_arb", 32'(arb_ack), 32'd1);
      check("nogrant_no_cyc", 32'(m_cyc), 32'd0);
      check("nogrant_no_vld", 32'(dat_vld), 32'd0);
      return;
    end

    lat = 0;
    while (!m_cyc && lat < 2 * CE_DIV + 2) begin
      step();
      lat++;
    end
    check("bus_start", 32'(m_cyc), 32'd1);
    check("bus_latency", 32'(lat <= 2 * CE_DIV + 1), 32'd1);
    if (!m_cyc) return;
    check("m_adr", 32'(m_adr), 32'(a));
    check("m_stb", 32'(m_stb), 32'd1);
    check("m_we", 32'(m_we), 32'd0);
    check("arb_ack_in_bus", 32'(arb_ack), 32'd0);

    if (rst_mid) begin
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_cyc", 32'(m_cyc), 32'd0);
      check("rst_mid_arb_ack", 32'(arb_ack), 32'd1);
      check("rst_mid_vld", 32'(dat_vld), 32'd0);
      check("rst_mid_err", 32'(err), 32'd0);
      check("rst_mid_dat", 32'(dat_o), 32'd0);
      exp_dat = '0;
      req = 8'h00;
      return;
    end

    cyc_clks = 1;
    nvld = 0;
    nerr = 0;
    req = 8'h00;  // requester drops out mid-transfer; the cycle must carry on
    m_ack_i = (dly == 0);
    m_dat_i = (dly == 0) ? d_v : DW'($urandom);
    for (int k = 1; k < TO + 10; k++) begin
      step();
      if (dat_vld) begin
        nvld++;
        check("dat_o", 32'(dat_o), 32'(d_v));
        check("dat_ch", 32'(dat_ch), 32'(ch));
        check("arb_ack_after_vld", 32'(arb_ack), 32'd1);
      end
      if (err) begin
        nerr++;
        check("dat_o_kept_on_err", 32'(dat_o), 32'(exp_dat));
        check("arb_ack_after_err", 32'(arb_ack), 32'd1);
      end
      if (m_cyc) cyc_clks++;
      m_ack_i = (k == dly);
      m_dat_i = (k == dly) ? d_v : DW'($urandom);
    end
    m_ack_i = 1'b0;

    check("vld_count", 32'(nvld), (dly < TO) ? 32'd1 : 32'd0);
    check("err_count", 32'(nerr), (dly < TO) ? 32'd0 : 32'd1);
    check("cyc_clks", 32'(cyc_clks), 32'(((dly < TO - 1) ? dly : TO - 1) + 1));
    if (dly < TO) exp_dat = d_v;
  endtask

  initial begin
    int ch, dly;
    logic [7:0] sel_v, req_v;

    rst = 1'b1;
    req = '0;
    sel = '0;
    seln = '0;
    addr_flat = '0;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    repeat (3) step();
    rst = 1'b0;

    check("rst_arb_ack", 32'(arb_ack), 32'd1);
    check("rst_m_cyc", 32'(m_cyc), 32'd0);
    check("rst_m_stb", 32'(m_stb), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_adr", 32'(m_adr), 32'd0);
    check("rst_dat_o", 32'(dat_o), 32'd0);
    check("rst_dat_ch", 32'(dat_ch), 32'd0);
    check("rst_dat_vld", 32'(dat_vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Idle with no grant: arb_ack alternates each ce. A stray bus ack is
    // held high the whole time and must be ignored outside BUS.
    m_ack_i = 1'b1;
    m_dat_i = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      wait_ce();
      check("idle_arb_ack", 32'(arb_ack), 32'(i % 2));
      check("idle_m_cyc", 32'(m_cyc), 32'd0);
      check("idle_stray_ack", 32'(dat_vld), 32'd0);
    end
    m_ack_i = 1'b0;
    check("idle_dat_o", 32'(dat_o), 32'd0);

    run_txn(3, 8'h08, 8'h08, 24'h001230, 16'hBEEF, 2, 1'b0);       // basic fetch
    run_txn(5, 8'h20, 8'h00, 24'h00ABCD, 16'h0000, 0, 1'b0);       // stale grant
    run_txn(1, 8'h02, 8'h02, 24'h000400, 16'h1111, 20, 1'b0);      // timeout
    run_txn(6, 8'h40, 8'hFF, 24'hFFFFFE, 16'h5A5A, TO - 1, 1'b0);  // ack on last count
    run_txn(0, 8'h01, 8'h01, 24'h000010, 16'h0F0F, 0, 1'b0);       // immediate ack
    run_txn(2, 8'h04, 8'h04, 24'h000222, 16'h2222, 0, 1'b1);       // reset mid-bus
    run_txn(7, 8'h00, 8'hFF, 24'h000777, 16'h7777, 0, 1'b0);       // no grant at all

    for (int n = 0; n < 16; n++) begin
      ch    = int'($urandom_range(0, 7));
      sel_v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'(1 << ch);
      req_v = 8'($urandom);
      if ($urandom_range(0, 3) != 0) req_v[ch] = 1'b1;
      dly   = int'($urandom_range(0, 6));
      run_txn(ch, sel_v, req_v, AW'($urandom), DW'($urandom), dly, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
